// File: rtl/viterbi_bm_sched.sv
// Branch-metric scheduler: walks every trellis state of one soft symbol
// through the BMU and streams indexed metrics to the ACS array.
module viterbi_bm_sched #(
  parameter int WIDTH_BM = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk_i,
  input  logic                rst_an_i,
  input  logic                flush_i,
  input  logic [1:0]          register_num_i,
  input  logic [23:0]         sym_data_i,
  input  logic                sym_valid_i,
  output logic                sym_ready_o,
  output logic                bmu_frame_start_o,
  output logic [5:0]          bmu_state_x_o,
  output logic [23:0]         bmu_soft_data_o,
  output logic                bmu_soft_data_valid_o,
  input  logic                bmu_ready_i,
  input  logic [WIDTH_BM-1:0] bmu_bm_i,
  input  logic                bmu_bm_valid_i,
  output logic [WIDTH_BM-1:0] bm_o,
  output logic [5:0]          bm_state_o,
  output logic                bm_valid_o,
  output logic                bm_last_o,
  output logic                busy_o,
  output logic                error_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_RDY,
    S_ISSUE,
    S_WAIT_BM
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          x_q, x_d;
  logic [5:0]          nlast_q, nlast_d;
  logic [23:0]         sym_q, sym_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [WIDTH_BM-1:0] bm_q, bm_d;
  logic [5:0]          bmst_q, bmst_d;
  logic                bmv_q, bmv_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                tmo, is_last;

  assign cnt_inc = cnt_q + CW'(1);
  assign tmo     = (cnt_inc == CW'(TIMEOUT));
  assign is_last = (x_q == nlast_q);

  assign sym_ready_o           = (state_q == S_IDLE) && !flush_i;
  assign bmu_frame_start_o     = (state_q == S_LOAD);
  assign bmu_soft_data_valid_o = (state_q == S_ISSUE);
  assign busy_o                = (state_q != S_IDLE);
  assign bmu_state_x_o         = x_q;
  assign bmu_soft_data_o       = sym_q;
  assign bm_o                  = bm_q;
  assign bm_state_o            = bmst_q;
  assign bm_valid_o            = bmv_q;
  assign bm_last_o             = last_q;
  assign error_o               = err_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    nlast_d = nlast_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    bm_d    = bm_q;
    bmst_d  = bmst_q;
    bmv_d   = 1'b0;
    last_d  = 1'b0;
    err_d   = err_q;
    if (flush_i) begin
      state_d = S_IDLE;
      x_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sym_valid_i) begin
            sym_d   = sym_data_i;
            nlast_d = 6'h3f >> register_num_i;
            x_d     = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_d   = '0;
          state_d = S_WAIT_RDY;
        end
        S_WAIT_RDY: begin
          // first cycle skipped: BMU ready still reflects the previous state
          cnt_d = cnt_inc;
          if (cnt_q != '0 && bmu_ready_i) begin
            state_d = S_ISSUE;
          end else if (tmo) begin
            err_d   = 1'b1;
            x_d     = '0;
            state_d = S_IDLE;
          end
        end
        S_ISSUE: begin
          cnt_d   = '0;
          state_d = S_WAIT_BM;
        end
        S_WAIT_BM: begin
          if (bmu_bm_valid_i) begin
            bm_d   = bmu_bm_i;
            bmst_d = x_q;
            bmv_d  = 1'b1;
            last_d = is_last;
            if (is_last) begin
              state_d = S_IDLE;
            end else begin
              x_d     = x_q + 6'd1;
              state_d = S_LOAD;
            end
          end else begin
            cnt_d = cnt_inc;
            if (tmo) begin
              err_d   = 1'b1;
              x_d     = '0;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_an_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      nlast_q <= '0;
      sym_q   <= '0;
      cnt_q   <= '0;
      bm_q    <= '0;
      bmst_q  <= '0;
      bmv_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      nlast_q <= nlast_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
      bm_q    <= bm_d;
      bmst_q  <= bmst_d;
      bmv_q   <= bmv_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_viterbi_bm_sched.sv
// Scoreboard bench for viterbi_bm_sched with a reactive BMU model.
module tb_viterbi_bm_sched;

  logic        clk = 1'b0;
  logic        rst_an_i, flush_i;
  logic [1:0]  register_num_i;
  logic [23:0] sym_data_i;
  logic        sym_valid_i, sym_ready_o;
  logic        bmu_frame_start_o;
  logic [5:0]  bmu_state_x_o;
  logic [23:0] bmu_soft_data_o;
  logic        bmu_soft_data_valid_o;
  logic        bmu_ready_i;
  logic [7:0]  bmu_bm_i;
  logic        bmu_bm_valid_i;
  logic [7:0]  bm_o;
  logic [5:0]  bm_state_o;
  logic        bm_valid_o, bm_last_o, busy_o, error_o;

  viterbi_bm_sched #(.WIDTH_BM(8), .TIMEOUT(15)) dut (
    .clk_i(clk), .rst_an_i(rst_an_i), .flush_i(flush_i),
    .register_num_i(register_num_i), .sym_data_i(sym_data_i),
    .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o),
    .bmu_frame_start_o(bmu_frame_start_o), .bmu_state_x_o(bmu_state_x_o),
    .bmu_soft_data_o(bmu_soft_data_o),
    .bmu_soft_data_valid_o(bmu_soft_data_valid_o),
    .bmu_ready_i(bmu_ready_i), .bmu_bm_i(bmu_bm_i),
    .bmu_bm_valid_i(bmu_bm_valid_i), .bm_o(bm_o), .bm_state_o(bm_state_o),
    .bm_valid_o(bm_valid_o), .bm_last_o(bm_last_o), .busy_o(busy_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] bm; logic [5:0] st; logic last; logic rdy; int cyc;
  } obs_t;
  typedef struct packed {
    logic [7:0] bm; logic [5:0] st; logic last;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic rdy_en = 1'b1;

  function automatic logic [7:0] bmf(input logic [23:0] s, input logic [5:0] x);
    return (s[7:0] ^ s[23:16] ^ {x, 2'b01}) + s[15:8];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bm_valid_o)
      obs_q.push_back({bm_o, bm_state_o, bm_last_o, sym_ready_o, cyc});

  // nominal BMU: ready 3 cycles after frame_start, metric 1 cycle after request
  int         since = 100;
  logic       pend = 1'b0;
  logic [7:0] pend_bm = '0;
  always @(negedge clk) begin
    if (bmu_frame_start_o) since = 0;
    else if (since < 100) since = since + 1;
    bmu_ready_i    = rdy_en && since >= 3;
    bmu_bm_valid_i = pend;
    bmu_bm_i       = pend_bm;
    pend           = bmu_soft_data_valid_o;
    pend_bm        = bmf(bmu_soft_data_o, bmu_state_x_o);
  end

  task automatic send_sym(input logic [23:0] d, input logic [1:0] rn,
                          input int push_n, output int acc);
    logic [5:0] nl;
    @(negedge clk);
    sym_valid_i = 1'b1; sym_data_i = d; register_num_i = rn;
    for (int k = 0; k < 3000 && !sym_ready_o; k++) @(negedge clk);
    acc = cyc;
    n_cmp++;
    if (sym_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL accept: sym_ready_o=%b want 1 (data %h)", sym_ready_o, d);
    end
    @(negedge clk);
    sym_valid_i = 1'b0;
    nl = 6'h3f >> rn;
    for (int x = 0; x < push_n; x++)
      exp_q.push_back({bmf(d, 6'(x)), 6'(x), 6'(x) == nl});
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    for (int k = 0; k < budget && obs_q.size() < n; k++) @(negedge clk);
    ok = obs_q.size() >= n;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_an_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_an_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_an_i = 1'b0; flush_i = 1'b0; register_num_i = 2'b00;
    sym_data_i = '0; sym_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_o, error_o, bm_valid_o, bm_last_o, bmu_frame_start_o,
         bmu_soft_data_valid_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000", {busy_o, error_o,
               bm_valid_o, bm_last_o, bmu_frame_start_o, bmu_soft_data_valid_o});
    end
    n_cmp++;
    if ({bmu_state_x_o, bmu_soft_data_o, bm_o, bm_state_o} !== 44'd0) begin
      n_bad++;
      $display("FAIL reset_data: x=%h sd=%h bm=%h st=%h want 0", bmu_state_x_o,
               bmu_soft_data_o, bm_o, bm_state_o);
    end
    rst_an_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sym_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_ready: got %b want 1", sym_ready_o);
    end
  endtask

  task automatic test_eight_states();
    int a; bit ok; obs_t o; exp_t e; int prev;
    send_sym(24'h123456, 2'b11, 8, a);
    wait_obs(8, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL eight_count: got %0d want 8", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if ({o.bm, o.st, o.last} !== {e.bm, e.st, e.last}) begin
        n_bad++;
        $display("FAIL eight[%0d]: got bm=%h st=%0d last=%b want bm=%h st=%0d last=%b",
                 i, o.bm, o.st, o.last, e.bm, e.st, e.last);
      end
      n_cmp++;
      if (i == 0 && o.cyc !== a + 7) begin
        n_bad++;
        $display("FAIL first_latency: got cyc %0d want %0d", o.cyc, a + 7);
      end else if (i > 0 && o.cyc - prev !== 6) begin
        n_bad++;
        $display("FAIL spacing[%0d]: got %0d want 6", i, o.cyc - prev);
      end
      if (i == 7) begin
        n_cmp++;
        if (o.rdy !== 1'b1) begin
          n_bad++;
          $display("FAIL ready_after_last: got %b want 1", o.rdy);
        end
      end
      prev = o.cyc;
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, n_last, c_last; bit ok; obs_t o; exp_t e;
    n_last = 0; c_last = -1;
    send_sym(24'h9a5c31, 2'b00, 64, a1);
    send_sym(24'h0ff0e7, 2'b00, 64, a2);
    wait_obs(128, 1200, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want 128", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.last) begin
        n_last++;
        if (c_last < 0) c_last = o.cyc;
      end
      n_cmp++;
      if ({o.bm, o.st, o.last} !== {e.bm, e.st, e.last}) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got bm=%h st=%0d last=%b want bm=%h st=%0d last=%b",
                 i, o.bm, o.st, o.last, e.bm, e.st, e.last);
      end
    end
    n_cmp++;
    if (n_last !== 2) begin
      n_bad++;
      $display("FAIL b2b_lasts: got %0d want 2", n_last);
    end
    n_cmp++;
    if (a2 < c_last) begin
      n_bad++;
      $display("FAIL b2b_accept: got cyc %0d want >= %0d", a2, c_last);
    end
  endtask

  task automatic test_timeout();
    int a; bit ok; obs_t o; exp_t e;
    rdy_en = 1'b0;
    send_sym(24'habcdef, 2'b11, 0, a);
    while (cyc < a + 16) @(negedge clk);
    n_cmp++;
    if ({error_o, busy_o} !== 2'b01) begin
      n_bad++;
      $display("FAIL tmo_early: err/busy=%b want 01", {error_o, busy_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({error_o, busy_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL tmo_flag: err/busy=%b want 10", {error_o, busy_o});
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_bad++;
      $display("FAIL tmo_strobes: got %0d want 0", obs_q.size());
      obs_q.delete();
    end
    rdy_en = 1'b1;
    send_sym(24'h5a5a5a, 2'b11, 8, a);
    wait_obs(8, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL tmo_good_count: got %0d want 8", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if ({o.bm, o.st, o.last} !== {e.bm, e.st, e.last}) begin
        n_bad++;
        $display("FAIL tmo_good[%0d]: got bm=%h st=%0d want bm=%h st=%0d",
                 i, o.bm, o.st, e.bm, e.st);
      end
    end
    n_cmp++;
    if (error_o !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b want 1", error_o);
    end
  endtask

  task automatic test_reset_mid();
    int a, fs; obs_t o; exp_t e;
    fs = 0;
    send_sym(24'h3c3c3c, 2'b11, 2, a);
    for (int k = 0; k < 100 && !(bmu_frame_start_o && bmu_state_x_o == 6'd2); k++)
      @(negedge clk);
    @(negedge clk);
    rst_an_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy_o, error_o, bm_valid_o, bm_last_o, bmu_frame_start_o,
         bmu_soft_data_valid_o, bmu_state_x_o, bmu_soft_data_o,
         bm_o, bm_state_o} !== 50'd0) begin
      n_bad++;
      $display("FAIL mid_reset: busy=%b err=%b x=%h sd=%h bm=%h st=%h want all 0",
               busy_o, error_o, bmu_state_x_o, bmu_soft_data_o, bm_o, bm_state_o);
    end
    rst_an_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bmu_frame_start_o) fs++;
    end
    n_cmp++;
    if (fs !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_fs: got %0d pulses want 0", fs);
    end
    n_cmp++;
    if (obs_q.size() !== 2) begin
      n_bad++;
      $display("FAIL mid_reset_count: got %0d want 2", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if ({o.bm, o.st, o.last} !== {e.bm, e.st, e.last}) begin
        n_bad++;
        $display("FAIL mid_reset[%0d]: got bm=%h st=%0d want bm=%h st=%0d",
                 i, o.bm, o.st, e.bm, e.st);
      end
    end
  endtask

  task automatic test_flush();
    int a; bit ok; obs_t o; exp_t e;
    send_sym(24'h77aa11, 2'b10, 5, a);
    for (int k = 0; k < 200 && !(bmu_soft_data_valid_o && bmu_state_x_o == 6'd5); k++)
      @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_busy: got %b want 0", busy_o);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (obs_q.size() !== 5) begin
      n_bad++;
      $display("FAIL flush_count: got %0d want 5", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end
    send_sym(24'he1d2c3, 2'b10, 16, a);
    wait_obs(21, 300, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL flush_restart_count: got %0d want 21", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if ({o.bm, o.st, o.last} !== {e.bm, e.st, e.last}) begin
        n_bad++;
        $display("FAIL flush[%0d]: got bm=%h st=%0d last=%b want bm=%h st=%0d last=%b",
                 i, o.bm, o.st, o.last, e.bm, e.st, e.last);
      end
    end
  endtask

  task automatic test_regnum_change();
    int a; bit ok; obs_t o; exp_t e;
    send_sym(24'h2468ac, 2'b10, 16, a);
    register_num_i = 2'b11;
    send_sym(24'h13579b, 2'b11, 8, a);
    wait_obs(24, 400, ok);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (obs_q.size() !== 24) begin
      n_bad++;
      $display("FAIL regnum_count: got %0d want 24", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if ({o.bm, o.st, o.last} !== {e.bm, e.st, e.last}) begin
        n_bad++;
        $display("FAIL regnum[%0d]: got bm=%h st=%0d last=%b want bm=%h st=%0d last=%b",
                 i, o.bm, o.st, o.last, e.bm, e.st, e.last);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_eight_states();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_flush();
    test_regnum_change();
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/viterbi_bm_sched.md
Name: viterbi_bm_sched

Overview:
- Per-symbol sequencer for the Branch Metric Unit.
- Accepts one 24-bit soft symbol (six 4-bit soft bits) through a valid/ready handshake.
- Walks every trellis state x = 0..N-1 through the BMU: load state, wait for BMU ready, fire soft data, capture the metric.
- Emits an indexed branch-metric stream (metric, state, last flag) to the downstream ACS array.

Parameters:
- WIDTH_BM, 8, branch metric width; matches the BMU bm output.
- TIMEOUT, 15, maximum cycles to wait for bmu_ready_i before flagging an error.

Ports:
- clk_i  in  1  clock.
- rst_an_i  in  1  synchronous active-low reset.
- flush_i  in  1  synchronous abort to IDLE; does not clear error_o.
- register_num_i  in  2  constraint memory select: 00=64, 01=32, 10=16, 11=8 states.
- sym_data_i  in  24  soft symbol.
- sym_valid_i  in  1  symbol valid.
- sym_ready_o  out  1  symbol accept; transfer when sym_valid_i & sym_ready_o.
- bmu_frame_start_o  out  1  one-cycle load pulse to the BMU.
- bmu_state_x_o  out  6  current state index to the BMU.
- bmu_soft_data_o  out  24  latched symbol to the BMU.
- bmu_soft_data_valid_o  out  1  one-cycle metric request.
- bmu_ready_i  in  1  BMU codeword ready.
- bmu_bm_i  in  WIDTH_BM  BMU metric.
- bmu_bm_valid_i  in  1  BMU metric valid.
- bm_o  out  WIDTH_BM  registered metric.
- bm_state_o  out  6  state index belonging to bm_o.
- bm_valid_o  out  1  metric strobe.
- bm_last_o  out  1  high with the strobe for the final state (x = N-1).
- busy_o  out  1  FSM not in IDLE.
- error_o  out  1  sticky BMU timeout.

Behaviour:
- Reset (rst_an_i=0 at clk_i edge):
  - FSM goes to IDLE.
  - All outputs 0, including bmu_state_x_o, bmu_soft_data_o and error_o.
  - Symbol register and counters cleared.
- States: IDLE, LOAD, WAIT_RDY, ISSUE, WAIT_BM.
- IDLE:
  - sym_ready_o = 1 combinationally.
  - On transfer: latch sym_data_i into bmu_soft_data_o.
  - Latch N from register_num_i; N is frozen for the whole symbol, and later register_num_i changes are ignored until the next transfer.
  - x = 0, go to LOAD.
- LOAD:
  - bmu_frame_start_o = 1 for exactly this cycle.
  - bmu_state_x_o = x, held constant until x advances.
  - Clear the wait counter; go to WAIT_RDY.
- WAIT_RDY:
  - bmu_ready_i is not sampled in the first WAIT_RDY cycle; BMU ready is still stale there.
  - From the second cycle on, bmu_ready_i = 1 moves to ISSUE.
  - The wait counter increments every WAIT_RDY cycle.
  - When the counter reaches TIMEOUT: set error_o (sticky until reset), return to IDLE, emit no metric for this symbol.
- ISSUE: bmu_soft_data_valid_o = 1 for one cycle; go to WAIT_BM.
- WAIT_BM:
  - On bmu_bm_valid_i: register bm_o = bmu_bm_i, bm_state_o = x, bm_valid_o = 1 on the next cycle.
  - bm_last_o = (x == N-1) in the same cycle as bm_valid_o.
  - If x == N-1: go to IDLE. Otherwise x++ and go to LOAD.
  - bmu_bm_valid_i not seen within TIMEOUT cycles: same handling as the WAIT_RDY timeout.
- Latency with the nominal BMU (ready 3 cycles after frame_start, bm 1 cycle after soft_data_valid):
  - LOAD at t, ISSUE at t+4, WAIT_BM at t+5, bm_valid_o at t+6.
  - Next LOAD at t+6, so 6 cycles per state.
  - First bm_valid_o 6 cycles after the LOAD that follows acceptance; 64-state symbol = 384 cycles.
- Output timing: bm_valid_o and bm_last_o are single-cycle pulses; bm_o and bm_state_o hold their values between strobes.
- busy_o = 1 in every state except IDLE. The cycle that returns to IDLE shows busy_o = 1. The next symbol is accepted at the earliest 1 cycle after the last strobe's transition.
- Widths: x counts 0..63 in a 6-bit register; compare against N-1 only, never rely on wrap.
- flush_i:
  - Has priority over every transition except reset.
  - Goes to IDLE and clears x; the symbol is dropped.
  - Suppresses any bm_valid_o due that cycle.
- Reset or flush during LOAD or ISSUE: the pulse for that cycle is still driven combinationally by the current state; nothing follows it.
- bmu_bm_valid_i outside WAIT_BM is ignored.
- sym_valid_i while busy_o = 1: sym_ready_o = 0, no transfer.

Test Plan:
- register_num_i=11, one symbol 0x123456, nominal BMU model:
  - 8 strobes, bm_state_o 0..7, bm_last_o only at state 7.
  - 6 cycles between strobes; sym_ready_o high again after the last strobe.
- register_num_i=00, two back-to-back symbols: 128 strobes; states 0..63 twice; exactly two bm_last_o pulses; second symbol accepted only after the first last strobe.
- BMU model never raises ready:
  - error_o set after TIMEOUT=15 WAIT_RDY cycles; FSM back to IDLE; no bm_valid_o.
  - error_o stays set after a later good symbol; cleared only by rst_an_i=0.
- flush_i asserted at the state-5 WAIT_BM cycle of a 16-state symbol:
  - No strobe for state 5 or later; busy_o=0 the next cycle.
  - New symbol restarts at state 0.
- Change register_num_i from 10 to 11 mid-symbol: still 16 strobes for that symbol; the next symbol yields 8.
- Synchronous reset mid-WAIT_RDY: all outputs 0 at the next edge, including error_o and bmu_state_x_o; no frame_start pulse until a new symbol is accepted.
